rgb_pwm_sequencer: RTL
======================

# rgb_pwm_sequencer

Three-channel PWM generator driving the `RGB0PWM`/`RGB1PWM`/`RGB2PWM` inputs of the SB_RGBA_DRV in the UPduino top level, replacing the ad-hoc per-LED counters there. Holds per-channel 8-bit duty values behind a double-buffered write port and optionally applies a triangle "breathing" envelope. A gate input lets an upstream source, such as the `blinky` `o_led`, blank all channels.

## Interface
- `PWM_BITS`, 8: width of the PWM counter and duty values; period = 2^PWM_BITS clocks.
- `BREATHE_DIV`, 16: PWM periods per breathing level step; range 1..65535.

- `i_clk`  in  1  system clock (6 MHz from SB_HFOSC div8).
- `i_reset`  in  1  reset; one clock, synchronous, active-high.
- `i_wr_stb`  in  1  write strobe; one write per cycle when high.
- `i_wr_chan`  in  2  write target: 0 = green, 1 = blue, 2 = red, 3 = mode.
- `i_wr_data`  in  PWM_BITS  duty value; for mode, bit0 = breathe_en, other bits ignored.
- `i_gate`  in  1  when 0, all PWM outputs forced low from the next cycle.
- `o_pwm_g`, `o_pwm_b`, `o_pwm_r`  out  1 each  registered PWM bits to RGB0PWM/RGB1PWM/RGB2PWM.
- `o_period_stb`  out  1  high for exactly the cycle in which `ctr` = 2^PWM_BITS−1.
- `o_pending`  out  1  registered; shadow written but not yet committed.

## Operation
- `ctr` (PWM_BITS) increments every clock and wraps from all-ones to 0.
- The wrap edge is the rising edge at which `ctr` = all-ones. All commits happen there.
- Shadow registers `sh_g`, `sh_b`, `sh_r`, `sh_mode` are loaded by `i_wr_stb` at the addressed channel.
- Active registers `act_*` load from the shadows only at the wrap edge. Duty never changes mid-period.
- If a write coincides with the wrap cycle, the new data is committed at that same edge (shadow bypass).
- `o_pending`:
  - Set by any write not coincident with the wrap cycle.
  - Cleared at the wrap edge.
  - A coincident write does not set it.
- Breathing envelope:
  - `level` (PWM_BITS) and `dir` (up/down), stepped by `pcnt`, which counts wraps modulo BREATHE_DIV.
  - At a wrap edge where `pcnt` = BREATHE_DIV−1 and committed breathe_en = 1, `level` steps by ±1.
  - Direction reverses on reaching all-ones (then down) or 0 (then up); endpoints are held for one step each, no skip.
  - While committed breathe_en = 0: `level` = 0, `dir` = up, `pcnt` = 0. Enabling therefore always ramps up from dark.
- Effective duty `eff_*` is registered at the wrap edge:
  - breathe off: `eff_x` = new `act_x`.
  - breathe on: `eff_x` = (new `act_x` × old `level`) >> PWM_BITS. Full 2·PWM_BITS-bit product, upper half kept, truncation only.
- Output: `o_pwm_x` <= `i_gate` & (`ctr` < `eff_x`).
  - Duty 0 gives a constant-low output.
  - Duty all-ones gives high for 2^PWM_BITS−1 of every 2^PWM_BITS cycles. 100% is unreachable by design.
- Reset clears everything to 0: `ctr`, `pcnt`, `level`, all shadow, active and eff registers, `o_pending`, all `o_pwm_*`, `o_period_stb`. `dir` = up.
- Reset mid-period aborts the period. Shadows written before reset are lost.

## Timing
- `o_pwm_x` has 1-cycle latency from the `ctr`/`i_gate` value that produced it. The first high output of a period appears one clock after `ctr` = 0.
- Write-to-effect latency:
  - Up to 2^PWM_BITS cycles until commit, plus 1 cycle on the output.
  - A write in the wrap cycle affects the very next period.
- `i_gate` falling: outputs low on the next edge; no period alignment.
- Breathing full cycle (0 → max → 0) = 2·(2^PWM_BITS−1)·BREATHE_DIV periods. At defaults this is 510·16·256 clocks ≈ 0.35 s at 6 MHz.
- Multiple writes to the same channel within one period: the last one wins.

## Test plan
- Reset, then write green = 0x40, blue = 0x00, red = 0xFF, gate = 1 → after the next wrap:
  - `o_pwm_g` high 64 of 256 cycles.
  - `o_pwm_b` never high.
  - `o_pwm_r` high 255 of 256 cycles, low only in the cycle after `ctr` = 255.
- Write green = 0x80 at `ctr` = 10 → `o_pending` = 1 until the wrap edge; output duty changes only in the following period, never mid-period.
- Write red = 0x20 exactly in the `o_period_stb` cycle → committed at that edge; next period red high for 32 cycles; `o_pending` stays 0.
- Breathe enable, green = 0xFF, BREATHE_DIV = 1, PWM_BITS = 4:
  - `level` runs 0,1,…,15,14,…,0,1.
  - `eff_g` = (15·old level) >> 4 each period.
  - Disabling resets `level` to 0.
- `i_gate` toggled 1→0 mid-pulse → all outputs low the next cycle; gate 1 again → resumes the current period's pattern without counter disturbance.
- Assert `i_reset` for one cycle mid-period with duties nonzero → next cycle all outputs 0 and `ctr` = 0; outputs stay low until duties are rewritten.

Source files
------------

// File: rtl/rgb_pwm_sequencer.sv
// Three-channel PWM sequencer with double-buffered duty registers and an
// optional triangle breathing envelope; all duty changes commit at the period wrap.
module rgb_pwm_sequencer #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned BREATHE_DIV = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_stb,
  input  logic [1:0]          i_wr_chan,
  input  logic [PWM_BITS-1:0] i_wr_data,
  input  logic                i_gate,
  output logic                o_pwm_g,
  output logic                o_pwm_b,
  output logic                o_pwm_r,
  output logic                o_period_stb,
  output logic                o_pending
);

  localparam int unsigned PW = PWM_BITS;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [PW-1:0] ctr_q, ctr_d;
  logic [PW-1:0] sh_g_q, sh_g_d, sh_b_q, sh_b_d, sh_r_q, sh_r_d;
  logic [PW-1:0] act_g_q, act_g_d, act_b_q, act_b_d, act_r_q, act_r_d;
  logic [PW-1:0] eff_g_q, eff_g_d, eff_b_q, eff_b_d, eff_r_q, eff_r_d;
  logic [PW-1:0] level_q, level_d;
  logic [15:0]   pcnt_q, pcnt_d;
  logic          sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic          pending_q, pending_d, stb_q, stb_d;
  logic          pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d, pwm_r_q, pwm_r_d;
  dir_e          dir_q, dir_d;
  logic          wrap, wr_g, wr_b, wr_r, wr_m;

  // Upper half of the full-width product, truncated.
  function automatic logic [PW-1:0] scale(input logic [PW-1:0] duty,
                                          input logic          en,
                                          input logic [PW-1:0] lvl);
    logic [2*PW-1:0] prod;
    prod = {{PW{1'b0}}, duty} * {{PW{1'b0}}, lvl};
    return en ? prod[2*PW-1:PW] : duty;
  endfunction

  assign wrap = (ctr_q == '1);
  assign wr_g = i_wr_stb && (i_wr_chan == 2'd0);
  assign wr_b = i_wr_stb && (i_wr_chan == 2'd1);
  assign wr_r = i_wr_stb && (i_wr_chan == 2'd2);
  assign wr_m = i_wr_stb && (i_wr_chan == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctr_q      <= '0;
      sh_g_q     <= '0;
      sh_b_q     <= '0;
      sh_r_q     <= '0;
      sh_mode_q  <= 1'b0;
      act_g_q    <= '0;
      act_b_q    <= '0;
      act_r_q    <= '0;
      act_mode_q <= 1'b0;
      eff_g_q    <= '0;
      eff_b_q    <= '0;
      eff_r_q    <= '0;
      level_q    <= '0;
      pcnt_q     <= '0;
      dir_q      <= DIR_UP;
      pending_q  <= 1'b0;
      stb_q      <= 1'b0;
      pwm_g_q    <= 1'b0;
      pwm_b_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      sh_g_q     <= sh_g_d;
      sh_b_q     <= sh_b_d;
      sh_r_q     <= sh_r_d;
      sh_mode_q  <= sh_mode_d;
      act_g_q    <= act_g_d;
      act_b_q    <= act_b_d;
      act_r_q    <= act_r_d;
      act_mode_q <= act_mode_d;
      eff_g_q    <= eff_g_d;
      eff_b_q    <= eff_b_d;
      eff_r_q    <= eff_r_d;
      level_q    <= level_d;
      pcnt_q     <= pcnt_d;
      dir_q      <= dir_d;
      pending_q  <= pending_d;
      stb_q      <= stb_d;
      pwm_g_q    <= pwm_g_d;
      pwm_b_q    <= pwm_b_d;
      pwm_r_q    <= pwm_r_d;
    end
  end

  always_comb begin
    ctr_d      = ctr_q + 1'b1;
    stb_d      = (ctr_d == '1);
    sh_g_d     = wr_g ? i_wr_data : sh_g_q;
    sh_b_d     = wr_b ? i_wr_data : sh_b_q;
    sh_r_d     = wr_r ? i_wr_data : sh_r_q;
    sh_mode_d  = wr_m ? i_wr_data[0] : sh_mode_q;
    act_g_d    = act_g_q;
    act_b_d    = act_b_q;
    act_r_d    = act_r_q;
    act_mode_d = act_mode_q;
    eff_g_d    = eff_g_q;
    eff_b_d    = eff_b_q;
    eff_r_d    = eff_r_q;
    level_d    = level_q;
    pcnt_d     = pcnt_q;
    dir_d      = dir_q;
    pending_d  = pending_q | i_wr_stb;

    if (wrap) begin
      // Shadow next-values already include a coincident write, giving the bypass.
      pending_d  = 1'b0;
      act_g_d    = sh_g_d;
      act_b_d    = sh_b_d;
      act_r_d    = sh_r_d;
      act_mode_d = sh_mode_d;
      eff_g_d    = scale(act_g_d, act_mode_d, level_q);
      eff_b_d    = scale(act_b_d, act_mode_d, level_q);
      eff_r_d    = scale(act_r_d, act_mode_d, level_q);
      if (act_mode_q) begin
        if (pcnt_q == 16'(BREATHE_DIV - 1)) begin
          pcnt_d = '0;
          if (dir_q == DIR_UP) begin
            level_d = level_q + 1'b1;
            if (level_d == '1) dir_d = DIR_DOWN;
          end else begin
            level_d = level_q - 1'b1;
            if (level_d == '0) dir_d = DIR_UP;
          end
        end else begin
          pcnt_d = pcnt_q + 16'd1;
        end
      end
    end

    if (!act_mode_q) begin
      level_d = '0;
      pcnt_d  = '0;
      dir_d   = DIR_UP;
    end
  end

  always_comb begin
    pwm_g_d = i_gate & (ctr_q < eff_g_q);
    pwm_b_d = i_gate & (ctr_q < eff_b_q);
    pwm_r_d = i_gate & (ctr_q < eff_r_q);
  end

  assign o_pwm_g      = pwm_g_q;
  assign o_pwm_b      = pwm_b_q;
  assign o_pwm_r      = pwm_r_q;
  assign o_period_stb = stb_q;
  assign o_pending    = pending_q;

endmodule
